// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the intersection controller:
//               phase state encoding, lamp patterns and phase-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Width of the phase counter; wide enough for 0..63 on the display.
  localparam int CNT_W = 6;

  // Lamp patterns, bit order {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Controller states; the six normal phases followed by maintenance flash.
  typedef enum logic [2:0] {
    ST_AR1   = 3'd0,
    ST_NSG   = 3'd1,
    ST_NSY   = 3'd2,
    ST_AR2   = 3'd3,
    ST_EWG   = 3'd4,
    ST_EWY   = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  // Successor of a normal phase in the fixed cycle. FLASH is never passed
  // here; it maps to AR1 so that any stray use restarts a clean cycle.
  function automatic state_e next_phase(input state_e cur);
    state_e nxt;
    case (cur)
      ST_AR1:  nxt = ST_NSG;
      ST_NSG:  nxt = ST_NSY;
      ST_NSY:  nxt = ST_AR2;
      ST_AR2:  nxt = ST_EWG;
      ST_EWG:  nxt = ST_EWY;
      ST_EWY:  nxt = ST_AR1;
      default: nxt = ST_AR1;
    endcase
    return nxt;
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_light_fsm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Down-counter for the current phase. Loads a phase length,
//               decrements on tick while above 1, optionally clamps the
//               remaining time to a cap, and flags the last tick of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = 6'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             trunc_en,
  input  logic [CNT_W-1:0] trunc_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             w_trunc;

  // Clamp only when the remaining time is above the cap; a clamp absorbs any
  // tick in the same cycle. Since the cap is at least 1, a clamp can never
  // coincide with the last tick of the phase.
  always_comb begin
    w_trunc = trunc_en && (r_count > trunc_val);
    done    = tick && (r_count == C_ONE) && !w_trunc;
  end

  // Counter register: explicit load beats clamp, clamp beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (w_trunc) begin
      r_count <= trunc_val;
    end else if (tick && (r_count > C_ONE)) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign count = r_count;

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_fsm
// Description : Two-road intersection sequencer. Cycles all-red / green /
//               yellow phases timed in ticks, shortens green on a pedestrian
//               request and offers a flashing-yellow maintenance mode. All
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_MIN  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             enable_i,
  input  logic             ped_req_i,
  output logic [2:0]       ns_light_o,
  output logic [2:0]       ew_light_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ped_pending_o
);

  localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] C_PEDMIN = CNT_W'(PED_MIN);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_flash;
  logic             w_flash_nxt;
  logic             r_ped;
  logic             w_ped_nxt;
  logic [2:0]       r_ns;
  logic [2:0]       r_ew;
  logic [2:0]       w_ns_nxt;
  logic [2:0]       w_ew_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_trunc_en;
  logic             w_done;
  logic             w_entry_ar;
  logic [CNT_W-1:0] w_count;

  // Length of a normal phase in ticks.
  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    logic [CNT_W-1:0] len;
    case (s)
      ST_NSG, ST_EWG: len = C_GREEN;
      ST_NSY, ST_EWY: len = C_YELLOW;
      default:        len = C_ALLRED;
    endcase
    return len;
  endfunction

  // A request arriving this very cycle already counts, so the green clamp
  // lands on the clock right after the request pulse.
  assign w_trunc_en = ((r_state == ST_NSG) || (r_state == ST_EWG)) &&
                      (r_ped || ped_req_i);

  phase_timer #(
    .RESET_VAL (C_ALLRED)
  ) u_phase_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .tick      (tick_i),
    .load      (w_load),
    .load_val  (w_load_val),
    .trunc_en  (w_trunc_en),
    .trunc_val (C_PEDMIN),
    .count     (w_count),
    .done      (w_done)
  );

  // Next-state, timer load, flash bit, pedestrian latch and lamp decode.
  always_comb begin
    w_state_nxt = r_state;
    w_flash_nxt = r_flash;
    w_load      = 1'b0;
    w_load_val  = C_ALLRED;
    w_ns_nxt    = LAMP_R;
    w_ew_nxt    = LAMP_R;

    if (!enable_i) begin
      // Maintenance wins over everything, including a tick this cycle. The
      // flash bit only toggles once we are already flashing.
      w_state_nxt = ST_FLASH;
      w_load      = 1'b1;
      w_load_val  = '0;
      if ((r_state == ST_FLASH) && tick_i) begin
        w_flash_nxt = ~r_flash;
      end
    end else if (r_state == ST_FLASH) begin
      w_state_nxt = ST_AR1;
      w_load      = 1'b1;
      w_load_val  = C_ALLRED;
      w_flash_nxt = 1'b0;
    end else if (w_done) begin
      w_state_nxt = next_phase(r_state);
      w_load      = 1'b1;
      w_load_val  = phase_len(w_state_nxt);
    end

    // Pending clears when an all-red phase is entered; a request in the
    // same cycle keeps it set.
    w_entry_ar = ((w_state_nxt == ST_AR1) || (w_state_nxt == ST_AR2)) &&
                 (w_state_nxt != r_state);
    w_ped_nxt  = ped_req_i | (r_ped & ~w_entry_ar);

    // Lamps are decoded from the next state so they register alongside it.
    case (w_state_nxt)
      ST_NSG:   begin w_ns_nxt = LAMP_G; w_ew_nxt = LAMP_R; end
      ST_NSY:   begin w_ns_nxt = LAMP_Y; w_ew_nxt = LAMP_R; end
      ST_EWG:   begin w_ns_nxt = LAMP_R; w_ew_nxt = LAMP_G; end
      ST_EWY:   begin w_ns_nxt = LAMP_R; w_ew_nxt = LAMP_Y; end
      ST_FLASH: begin
        w_ns_nxt = w_flash_nxt ? LAMP_Y : LAMP_OFF;
        w_ew_nxt = w_flash_nxt ? LAMP_Y : LAMP_OFF;
      end
      default:  begin w_ns_nxt = LAMP_R; w_ew_nxt = LAMP_R; end
    endcase
  end

  // State, flash bit, pedestrian latch and lamp registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_AR1;
      r_flash <= 1'b0;
      r_ped   <= 1'b0;
      r_ns    <= LAMP_R;
      r_ew    <= LAMP_R;
    end else begin
      r_state <= w_state_nxt;
      r_flash <= w_flash_nxt;
      r_ped   <= w_ped_nxt;
      r_ns    <= w_ns_nxt;
      r_ew    <= w_ew_nxt;
    end
  end

  assign ns_light_o    = r_ns;
  assign ew_light_o    = r_ew;
  assign count_o       = w_count;
  assign ped_pending_o = r_ped;

endmodule : traffic_light_fsm
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_fsm
// Description : Self-checking bench for traffic_light_fsm with default
//               timing (10/3/2/4) and a tick every 4 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       en = 1'b1;
  logic       req = 1'b0;
  logic [2:0] ns;
  logic [2:0] ew;
  logic [5:0] cnt;
  logic       pend;

  typedef struct {
    logic       tk;
    logic       en;
    logic       rq;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [5:0] cnt;
    logic       pend;
  } vec_t;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    int         len;
  } phase_t;

  vec_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .enable_i      (en),
    .ped_req_i     (req),
    .ns_light_o    (ns),
    .ew_light_o    (ew),
    .count_o       (cnt),
    .ped_pending_o (pend)
  );

  // Both roads green must never be observed.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ((ns == LAMP_G) && (ew == LAMP_G)) begin
        n_bad++;
        $display("FAIL no_conflict: got ns=%b ew=%b, both green not allowed", ns, ew);
      end
    end
  end

  task automatic pop_check(input string name);
    vec_t e;
    e = sbq.pop_front();
    n_cmp++;
    if ((ns !== e.ns) || (ew !== e.ew) || (cnt !== e.cnt) || (pend !== e.pend)) begin
      n_bad++;
      $display("FAIL %s: got ns=%b ew=%b cnt=%0d pend=%b, want ns=%b ew=%b cnt=%0d pend=%b",
               name, ns, ew, cnt, pend, e.ns, e.ew, e.cnt, e.pend);
    end
  endtask

  // One clock with the given inputs; outputs are compared 1 ns after the edge.
  task automatic step(input string name, input logic tk, input logic e, input logic r,
                      input logic [2:0] x_ns, input logic [2:0] x_ew,
                      input logic [5:0] x_cnt, input logic x_pend);
    vec_t v;
    v = '{tk, e, r, x_ns, x_ew, x_cnt, x_pend};
    sbq.push_back(v);
    tick = tk; en = e; req = r;
    @(posedge clk); #1;
    tick = 1'b0;
    pop_check(name);
  endtask

  task automatic idle(input int n, input logic e, input logic r);
    for (int k = 0; k < n; k++) begin
      tick = 1'b0; en = e; req = r;
      @(posedge clk); #1;
    end
  endtask

  // A tick period: tick cycle (checked) plus three quiet cycles.
  task automatic tstep(input string name, input logic r,
                       input logic [2:0] x_ns, input logic [2:0] x_ew,
                       input logic [5:0] x_cnt, input logic x_pend);
    step(name, 1'b1, 1'b1, r, x_ns, x_ew, x_cnt, x_pend);
    idle(3, 1'b1, 1'b0);
  endtask

  initial begin
    phase_t ph[6];
    vec_t   tbl[31];
    vec_t   v;
    int     n;

    ph[0] = '{LAMP_R, LAMP_R, 2};
    ph[1] = '{LAMP_G, LAMP_R, 10};
    ph[2] = '{LAMP_Y, LAMP_R, 3};
    ph[3] = '{LAMP_R, LAMP_R, 2};
    ph[4] = '{LAMP_R, LAMP_G, 10};
    ph[5] = '{LAMP_R, LAMP_Y, 3};
    n = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = ph[p].len; c >= 1; c--) begin
        tbl[n] = '{1'b1, 1'b1, 1'b0, ph[p].ns, ph[p].ew, 6'(c), 1'b0};
        n++;
      end
    end
    tbl[n] = '{1'b1, 1'b1, 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0};

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    v = '{1'b0, 1'b1, 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0};
    sbq.push_back(v);
    pop_check("reset");
    rst_n = 1'b1;

    // 1. Full normal cycle from the table.
    for (int i = 1; i < 31; i++) begin
      tstep($sformatf("cycle[%0d]", i), tbl[i].rq, tbl[i].ns, tbl[i].ew, tbl[i].cnt, tbl[i].pend);
    end

    // 2. Request at NSG count 8 truncates to 4.
    tstep("s2_ar1", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b0);
    tstep("s2_nsg10", 1'b0, LAMP_G, LAMP_R, 6'd10, 1'b0);
    tstep("s2_nsg9", 1'b0, LAMP_G, LAMP_R, 6'd9, 1'b0);
    tstep("s2_nsg8", 1'b0, LAMP_G, LAMP_R, 6'd8, 1'b0);
    step("s2_trunc", 1'b0, 1'b1, 1'b1, LAMP_G, LAMP_R, 6'd4, 1'b1);
    idle(2, 1'b1, 1'b0);
    for (int c = 3; c >= 1; c--) tstep("s2_nsg", 1'b0, LAMP_G, LAMP_R, 6'(c), 1'b1);
    for (int c = 3; c >= 1; c--) tstep("s2_nsy", 1'b0, LAMP_Y, LAMP_R, 6'(c), 1'b1);
    tstep("s2_ar2_clear", 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0);

    // 3. Request at EWG count 3: no truncation.
    tstep("s3_ar2", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b0);
    for (int c = 10; c >= 3; c--) tstep("s3_ewg", 1'b0, LAMP_R, LAMP_G, 6'(c), 1'b0);
    step("s3_no_trunc", 1'b0, 1'b1, 1'b1, LAMP_R, LAMP_G, 6'd3, 1'b1);
    idle(2, 1'b1, 1'b0);
    for (int c = 2; c >= 1; c--) tstep("s3_ewg_tail", 1'b0, LAMP_R, LAMP_G, 6'(c), 1'b1);
    for (int c = 3; c >= 1; c--) tstep("s3_ewy", 1'b0, LAMP_R, LAMP_Y, 6'(c), 1'b1);
    tstep("s3_ar1_clear", 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0);

    // 4. Flash mode entered mid-NSY, with a tick in the same cycle.
    tstep("s4_ar1", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b0);
    for (int c = 10; c >= 1; c--) tstep("s4_nsg", 1'b0, LAMP_G, LAMP_R, 6'(c), 1'b0);
    tstep("s4_nsy3", 1'b0, LAMP_Y, LAMP_R, 6'd3, 1'b0);
    tstep("s4_nsy2", 1'b0, LAMP_Y, LAMP_R, 6'd2, 1'b0);
    step("s4_flash_entry", 1'b1, 1'b0, 1'b0, LAMP_OFF, LAMP_OFF, 6'd0, 1'b0);
    idle(3, 1'b0, 1'b0);
    step("s4_flash_on", 1'b1, 1'b0, 1'b0, LAMP_Y, LAMP_Y, 6'd0, 1'b0);
    idle(3, 1'b0, 1'b0);
    step("s4_flash_off", 1'b1, 1'b0, 1'b0, LAMP_OFF, LAMP_OFF, 6'd0, 1'b0);
    idle(3, 1'b0, 1'b0);
    step("s4_flash_ped", 1'b0, 1'b0, 1'b1, LAMP_OFF, LAMP_OFF, 6'd0, 1'b1);
    step("s4_flash_exit", 1'b0, 1'b1, 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0);
    idle(3, 1'b1, 1'b0);

    // 5. Asynchronous reset mid-EWG.
    tstep("s5_ar1", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b0);
    for (int c = 10; c >= 1; c--) tstep("s5_nsg", 1'b0, LAMP_G, LAMP_R, 6'(c), 1'b0);
    for (int c = 3; c >= 1; c--) tstep("s5_nsy", 1'b0, LAMP_Y, LAMP_R, 6'(c), 1'b0);
    for (int c = 2; c >= 1; c--) tstep("s5_ar2", 1'b0, LAMP_R, LAMP_R, 6'(c), 1'b0);
    tstep("s5_ewg10", 1'b0, LAMP_R, LAMP_G, 6'd10, 1'b0);
    step("s5_ewg_trunc", 1'b0, 1'b1, 1'b1, LAMP_R, LAMP_G, 6'd4, 1'b1);
    idle(1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    v = '{1'b0, 1'b1, 1'b0, LAMP_R, LAMP_R, 6'd2, 1'b0};
    sbq.push_back(v);
    pop_check("s5_async_reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    tstep("s5_first_tick", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b0);

    // 6. Request held across AR2 entry keeps pending; EWG truncates at once.
    for (int c = 10; c >= 1; c--) tstep("s6_nsg", 1'b0, LAMP_G, LAMP_R, 6'(c), 1'b0);
    for (int c = 3; c >= 1; c--) tstep("s6_nsy", 1'b0, LAMP_Y, LAMP_R, 6'(c), 1'b0);
    step("s6_ar2_hold", 1'b1, 1'b1, 1'b1, LAMP_R, LAMP_R, 6'd2, 1'b1);
    idle(3, 1'b1, 1'b0);
    tstep("s6_ar2_1", 1'b0, LAMP_R, LAMP_R, 6'd1, 1'b1);
    step("s6_ewg_entry", 1'b1, 1'b1, 1'b0, LAMP_R, LAMP_G, 6'd10, 1'b1);
    step("s6_ewg_trunc", 1'b0, 1'b1, 1'b0, LAMP_R, LAMP_G, 6'd4, 1'b1);
    idle(2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_traffic_light_fsm
`default_nettype wire
